receive_nums: RTL and testbench
===============================

RECEIVE_NUMS -- requirements
Module: receive_nums

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, divClk cycles per UART bit (legal range 4..255).
REQ-002 SHALL have parameter SCAN_DIV, default 1, divClk cycles each display digit stays active (legal range 1..65535).
REQ-003 divClk  input  1  clock; all logic on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 serial1  input  1  UART line carrying number 1; idle high.
REQ-006 serial2  input  1  UART line carrying number 2; idle high.
REQ-007 disp  output  7  active-low segments; bit0=a … bit6=g.
REQ-008 segmentCount  output  4  active-low digit enables.
REQ-009 point  output  1  active-low decimal point.
REQ-010 num1, num2  output  7 each  last accepted value per line, binary 0..99.
REQ-011 valid1, valid2  output  1 each  one-cycle pulse when a new value is accepted.
REQ-012 err1, err2  output  1 each  one-cycle pulse when a frame is rejected.

Function
REQ-013 Each line SHALL have its own, fully independent receiver: 2-flop synchronizer, then FSM IDLE -> START -> DATA -> STOP -> IDLE.
REQ-014 Frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1).
REQ-015 IDLE: a synchronized low SHALL enter START and clear the bit counter.
REQ-016 START: at count CLKS_PER_BIT/2 (integer division), the line SHALL be sampled.
- Low: go to DATA and restart the counter.
- High (glitch): return to IDLE with no flag.
REQ-017 DATA: each data bit SHALL be sampled every CLKS_PER_BIT cycles after the mid-start sample; after bit 7 go to STOP.
REQ-018 STOP: the line SHALL be sampled CLKS_PER_BIT cycles after bit 7; the FSM then returns to IDLE in the next cycle, so back-to-back frames are accepted.
REQ-019 Stop sample 1 and byte <= 99: on the cycle after the stop sample, numN SHALL update and validN SHALL pulse.
REQ-020 Stop sample 0 (framing error), or byte > 99: errN SHALL pulse instead; numN is unchanged.
REQ-021 validN and errN SHALL never be high in the same cycle.
REQ-022 Tens and units SHALL be derived from numN: tens = numN/10, units = numN mod 10, 4 bits each.
REQ-023 Digit segment codes (active-low):
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
REQ-024 A 2-bit scan index SHALL advance every SCAN_DIV cycles and wrap 3 -> 0.
REQ-025 Scan map (index: segmentCount, digit shown, point):
- 0: 0111, num2 units, point 1
- 1: 1011, num2 tens, point 1
- 2: 1101, num1 units, point 0
- 3: 1110, num1 tens, point 1
REQ-026 disp, segmentCount and point SHALL be registered; they reflect the scan index and numN one cycle later.
REQ-027 A frame arriving on one line SHALL NOT delay or alter the other line or the display scan.

Reset
REQ-028 While rst is high, all state SHALL be forced:
- both FSMs in IDLE; counters, scan index, num1 and num2 = 0
- valid1/2 = 0, err1/2 = 0
- segmentCount = 0111, disp = 1000000, point = 1
REQ-029 rst asserted mid-frame SHALL abort the frame with no valid or err pulse.
REQ-030 After rst release, a line already low SHALL be treated as a start bit only after both synchronizer stages have seen it low.

Verification
REQ-031 Bench SHALL cover, with CLKS_PER_BIT=16 and SCAN_DIV=1:
- Send 0x2A on serial1 -> one valid1 pulse, num1=42; scan index 3 shows 0011001, index 2 shows 0100100 with point=0.
- Send 0x63 on serial2 and 0x07 on serial1 with overlapping frames -> num2=99 and num1=7, each with its own single valid pulse; display order 9,9,7,0 across indices 0..3.
- Send 0x64 on serial1 -> err1 pulse, no valid1, num1 keeps its prior value.
- Send a frame with stop bit 0 on serial2 -> err2 pulse, num2 unchanged; a correct 0x05 sent immediately after -> num2=5.
- Drive serial1 low for 5 cycles then high -> FSM back in IDLE, no valid1 or err1.
- Assert rst during data bit 4 of a frame -> all outputs at reset values, no pulses; a following full frame of 0x11 -> num1=17.

Source files
------------

// File: rtl/receive_nums.sv
// Two independent 8N1 UART receivers for values 0..99, shown on a 4-digit multiplexed 7-segment display.
// Value/valid/err are registered one cycle after the stop sample; display outputs are one register stage.

module uart_num_rx #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       divClk,
   input  logic       rst,
   input  logic       serial,
   output logic [6:0] num,
   output logic       valid,
   output logic       err
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   localparam logic [7:0] HALF = 8'(CLKS_PER_BIT / 2);
   localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);

   logic       sync1;
   logic       sync2;
   logic [1:0] state;
   logic [7:0] cnt;
   logic [2:0] bit_idx;
   logic [7:0] shift;

   // Synchronizer resets to idle-high so a line held low through reset needs two edges to register.
   always_ff @(posedge divClk or posedge rst) begin
      if (rst) begin
         sync1   <= 1'b1;
         sync2   <= 1'b1;
         state   <= IDLE;
         cnt     <= 8'd0;
         bit_idx <= 3'd0;
         shift   <= 8'd0;
         num     <= 7'd0;
         valid   <= 1'b0;
         err     <= 1'b0;
      end else begin
         sync1 <= serial;
         sync2 <= sync1;
         valid <= 1'b0;
         err   <= 1'b0;
         case (state)
            IDLE: begin
               if (!sync2) begin
                  state <= START;
                  cnt   <= 8'd0;
               end
            end
            START: begin
               if (cnt == HALF) begin
                  cnt     <= 8'd0;
                  bit_idx <= 3'd0;
                  state   <= sync2 ? IDLE : DATA;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            DATA: begin
               if (cnt == LAST) begin
                  cnt   <= 8'd0;
                  shift <= {sync2, shift[7:1]};
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                  end
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            STOP: begin
               if (cnt == LAST) begin
                  cnt   <= 8'd0;
                  state <= IDLE;
                  if (sync2 && (shift <= 8'd99)) begin
                     num   <= shift[6:0];
                     valid <= 1'b1;
                  end else begin
                     err <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

module receive_nums #(
   parameter int CLKS_PER_BIT = 16,
   parameter int SCAN_DIV     = 1
) (
   input  logic       divClk,
   input  logic       rst,
   input  logic       serial1,
   input  logic       serial2,
   output logic [6:0] disp,
   output logic [3:0] segmentCount,
   output logic       point,
   output logic [6:0] num1,
   output logic [6:0] num2,
   output logic       valid1,
   output logic       valid2,
   output logic       err1,
   output logic       err2
);
   localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

   logic [15:0] scan_cnt;
   logic [1:0]  scan_idx;
   logic [3:0]  tens1;
   logic [3:0]  units1;
   logic [3:0]  tens2;
   logic [3:0]  units2;

   uart_num_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) rx1 (
      .divClk (divClk),
      .rst    (rst),
      .serial (serial1),
      .num    (num1),
      .valid  (valid1),
      .err    (err1)
   );

   uart_num_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) rx2 (
      .divClk (divClk),
      .rst    (rst),
      .serial (serial2),
      .num    (num2),
      .valid  (valid2),
      .err    (err2)
   );

   assign tens1  = 4'(num1 / 7'd10);
   assign units1 = 4'(num1 % 7'd10);
   assign tens2  = 4'(num2 / 7'd10);
   assign units2 = 4'(num2 % 7'd10);

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'b1000000;
         4'd1:    seg7 = 7'b1111001;
         4'd2:    seg7 = 7'b0100100;
         4'd3:    seg7 = 7'b0110000;
         4'd4:    seg7 = 7'b0011001;
         4'd5:    seg7 = 7'b0010010;
         4'd6:    seg7 = 7'b0000010;
         4'd7:    seg7 = 7'b1111000;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0010000;
         default: seg7 = 7'b1111111;
      endcase
   endfunction

   // Outputs are registered from the current index, so they trail scan_idx by one cycle.
   always_ff @(posedge divClk or posedge rst) begin
      if (rst) begin
         scan_cnt     <= 16'd0;
         scan_idx     <= 2'd0;
         disp         <= 7'b1000000;
         segmentCount <= 4'b0111;
         point        <= 1'b1;
      end else begin
         if (scan_cnt == DIV_LAST) begin
            scan_cnt <= 16'd0;
            scan_idx <= scan_idx + 2'd1;
         end else begin
            scan_cnt <= scan_cnt + 16'd1;
         end
         case (scan_idx)
            2'd0: begin
               segmentCount <= 4'b0111;
               disp         <= seg7(units2);
               point        <= 1'b1;
            end
            2'd1: begin
               segmentCount <= 4'b1011;
               disp         <= seg7(tens2);
               point        <= 1'b1;
            end
            2'd2: begin
               segmentCount <= 4'b1101;
               disp         <= seg7(units1);
               point        <= 1'b0;
            end
            default: begin
               segmentCount <= 4'b1110;
               disp         <= seg7(tens1);
               point        <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_receive_nums.sv
// Randomized bench for receive_nums: drives UART frames on both lines and compares against a frame-level model.
module tb_receive_nums;
   localparam int CPB = 16;

   localparam logic [6:0] SEG [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                       7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
   localparam logic [3:0] ORDER [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

   logic       divClk = 1'b0;
   logic       rst = 1'b1;
   logic       serial1 = 1'b1;
   logic       serial2 = 1'b1;
   logic [6:0] disp;
   logic [3:0] segmentCount;
   logic       point;
   logic [6:0] num1;
   logic [6:0] num2;
   logic       valid1;
   logic       valid2;
   logic       err1;
   logic       err2;

   int total = 0;
   int bad = 0;

   // Frame-level model: last accepted values and expected pulse counts.
   int m1 = 0, m2 = 0;
   int ev1 = 0, ev2 = 0, ee1 = 0, ee2 = 0;

   // Observed pulse counts and protocol violations.
   int v1_cnt = 0, v2_cnt = 0, e1_cnt = 0, e2_cnt = 0;
   int viol = 0;
   logic pv1 = 1'b0, pv2 = 1'b0, pe1 = 1'b0, pe2 = 1'b0;

   receive_nums #(.CLKS_PER_BIT(CPB), .SCAN_DIV(1)) dut (
      .divClk       (divClk),
      .rst          (rst),
      .serial1      (serial1),
      .serial2      (serial2),
      .disp         (disp),
      .segmentCount (segmentCount),
      .point        (point),
      .num1         (num1),
      .num2         (num2),
      .valid1       (valid1),
      .valid2       (valid2),
      .err1         (err1),
      .err2         (err2)
   );

   always #5 divClk = ~divClk;

   always @(negedge divClk) begin
      if (valid1) v1_cnt++;
      if (valid2) v2_cnt++;
      if (err1) e1_cnt++;
      if (err2) e2_cnt++;
      if ((valid1 && err1) || (valid2 && err2)) viol++;
      if ((valid1 && pv1) || (valid2 && pv2) || (err1 && pe1) || (err2 && pe2)) viol++;
      pv1 = valid1;
      pv2 = valid2;
      pe1 = err1;
      pe2 = err2;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge divClk);
      #1;
   endtask

   task automatic drive(input int line, input logic v);
      if (line == 1) serial1 = v;
      else serial2 = v;
   endtask

   // Sends the first nbits of a start/data/stop frame; a bad stop bit is followed by one idle bit time.
   task automatic send_frame(input int line, input logic [7:0] b, input logic stop, input int nbits);
      logic [9:0] fr;
      fr = {stop, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         drive(line, fr[i]);
         tick(CPB);
      end
      drive(line, 1'b1);
      if (nbits == 10 && !stop) tick(CPB);
   endtask

   task automatic model_frame(input int line, input logic [7:0] b, input logic stop);
      if (stop && b <= 8'd99) begin
         if (line == 1) begin m1 = int'(b); ev1++; end
         else begin m2 = int'(b); ev2++; end
      end else begin
         if (line == 1) ee1++;
         else ee2++;
      end
   endtask

   task automatic check_state(input string tag);
      chk({tag, ".num1"}, num1, m1);
      chk({tag, ".num2"}, num2, m2);
      chk({tag, ".valid1"}, v1_cnt, ev1);
      chk({tag, ".valid2"}, v2_cnt, ev2);
      chk({tag, ".err1"}, e1_cnt, ee1);
      chk({tag, ".err2"}, e2_cnt, ee2);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, ".num1"}, num1, 0);
      chk({tag, ".num2"}, num2, 0);
      chk({tag, ".pulses"}, {valid1, valid2, err1, err2}, 4'b0000);
      chk({tag, ".disp"}, disp, 7'b1000000);
      chk({tag, ".sel"}, segmentCount, 4'b0111);
      chk({tag, ".point"}, point, 1'b1);
   endtask

   task automatic check_display(input string tag);
      int pos;
      int prev_pos;
      int d;
      prev_pos = -1;
      for (int c = 0; c < 6; c++) begin
         @(negedge divClk);
         pos = -1;
         for (int k = 0; k < 4; k++) if (segmentCount == ORDER[k]) pos = k;
         if (pos < 0) begin
            chk({tag, ".scan_sel"}, segmentCount, ORDER[0]);
         end else begin
            if (prev_pos >= 0) chk({tag, ".scan_rot"}, pos, (prev_pos + 1) % 4);
            case (pos)
               0: d = m2 % 10;
               1: d = m2 / 10;
               2: d = m1 % 10;
               default: d = m1 / 10;
            endcase
            chk({tag, ".disp"}, disp, SEG[d]);
            chk({tag, ".point"}, point, (pos == 2) ? 1'b0 : 1'b1);
         end
         prev_pos = pos;
      end
      tick(1);
   endtask

   initial begin
      logic [7:0] b1, b2;
      logic s1, s2;
      int d1, d2;

      tick(3);
      check_reset_outputs("reset");
      rst = 1'b0;
      tick(4);
      check_state("idle");

      send_frame(1, 8'h2A, 1'b1, 10);
      model_frame(1, 8'h2A, 1'b1);
      tick(4);
      check_state("f2a");
      check_display("f2a");

      fork
         send_frame(2, 8'h63, 1'b1, 10);
         begin
            tick(37);
            send_frame(1, 8'h07, 1'b1, 10);
         end
      join
      model_frame(2, 8'h63, 1'b1);
      model_frame(1, 8'h07, 1'b1);
      tick(4);
      check_state("overlap");
      check_display("overlap");

      send_frame(1, 8'h64, 1'b1, 10);
      model_frame(1, 8'h64, 1'b1);
      tick(4);
      check_state("over99");

      send_frame(2, 8'h21, 1'b0, 10);
      model_frame(2, 8'h21, 1'b0);
      send_frame(2, 8'h05, 1'b1, 10);
      model_frame(2, 8'h05, 1'b1);
      tick(4);
      check_state("badstop");

      serial1 = 1'b0;
      tick(5);
      serial1 = 1'b1;
      tick(30);
      check_state("glitch");
      send_frame(1, 8'h30, 1'b1, 10);
      model_frame(1, 8'h30, 1'b1);
      tick(4);
      check_state("post_glitch");

      send_frame(1, 8'h5A, 1'b1, 5);
      tick(4);
      rst = 1'b1;
      m1 = 0;
      m2 = 0;
      tick(3);
      check_reset_outputs("midreset");
      rst = 1'b0;
      tick(CPB * 12);
      check_state("midreset_after");
      send_frame(1, 8'h11, 1'b1, 10);
      model_frame(1, 8'h11, 1'b1);
      tick(4);
      check_state("f11");

      for (int it = 0; it < 16; it++) begin
         b1 = 8'($urandom_range(0, 255));
         b2 = 8'($urandom_range(0, 255));
         s1 = ($urandom_range(0, 3) != 0);
         s2 = ($urandom_range(0, 3) != 0);
         d1 = $urandom_range(0, 30);
         d2 = $urandom_range(0, 30);
         fork
            begin tick(d1 + 1); send_frame(1, b1, s1, 10); end
            begin tick(d2 + 1); send_frame(2, b2, s2, 10); end
         join
         model_frame(1, b1, s1);
         model_frame(2, b2, s2);
         tick(4);
         check_state($sformatf("rand%0d", it));
      end
      check_display("rand_end");

      chk("protocol_viol", viol, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
